// File: rtl/user_str_pkg.sv
// Shared definitions for the user stream FIFO: register map, STATUS layout
// and interrupt FSM encoding.
package user_str_pkg;

  localparam logic [3:0] OFS_LEN    = 4'h0;
  localparam logic [3:0] OFS_CNT    = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;
  localparam logic [3:0] OFS_CTRL   = 4'hC;

  localparam int unsigned STATUS_FULL_BIT  = 9;
  localparam int unsigned STATUS_EMPTY_BIT = 8;
  localparam int unsigned STATUS_FILL_W    = 8;
  localparam int unsigned CTRL_FLUSH_BIT   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PEND  = 2'd2
  } intr_state_e;

  function automatic logic [31:0] pack_status(input logic                     full,
                                              input logic                     empty,
                                              input logic [STATUS_FILL_W-1:0] fill);
    logic [31:0] s;
    s                      = '0;
    s[STATUS_FULL_BIT]     = full;
    s[STATUS_EMPTY_BIT]    = empty;
    s[STATUS_FILL_W-1:0]   = fill;
    return s;
  endfunction

endpackage

// File: rtl/user_str_fifo_ram.sv
// DEPTH x WIDTH storage with one synchronous write port and one asynchronous
// read port, shaped to map onto distributed RAM.
module user_str_fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; clearing it would block RAM inference, and
  // the FIFO's empty flag already hides stale contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/user_str_fifo.sv
// First-word-fall-through stream FIFO with a small register window for block
// length, pop count, status, flush and a block-complete interrupt.
module user_str_fifo
  import user_str_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [19:0] BASE_ADDR = 20'h00100
) (
  input  logic        i_user_clk,
  input  logic        i_rst,
  input  logic        i_pcie_str_data_valid,
  output logic        o_pcie_str_ack,
  input  logic [63:0] i_pcie_str_data,
  output logic        o_user_str_data_valid,
  input  logic        i_user_str_ack,
  output logic [63:0] o_user_str_data,
  input  logic [19:0] i_user_addr,
  input  logic [31:0] i_user_data,
  input  logic        i_user_wr_req,
  input  logic        i_user_rd_req,
  output logic [31:0] o_user_data,
  output logic        o_user_rd_ack,
  output logic        o_intr_req,
  input  logic        i_intr_ack
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [31:0]   len_q, len_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   rd_data_q;
  logic          rd_ack_q;
  intr_state_e   state_q;
  logic          intr_req_q;

  logic          full, empty, push, pop;
  logic          in_window, len_wr, flush;
  logic [63:0]   ram_rdata;

  assign full  = (fill_q == FULL_LVL);
  assign empty = (fill_q == '0);
  assign pop   = !empty && i_user_str_ack;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push  = i_pcie_str_data_valid && (!full || pop);

  assign in_window = (i_user_addr[19:4] == BASE_ADDR[19:4]);
  assign len_wr    = i_user_wr_req && in_window && (i_user_addr[3:0] == OFS_LEN);
  assign flush     = i_user_wr_req && in_window && (i_user_addr[3:0] == OFS_CTRL)
                     && i_user_data[CTRL_FLUSH_BIT];

  user_str_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_ram (
    .clk_i   (i_user_clk),
    .we_i    (push && !flush && i_rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_pcie_str_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    len_d    = len_q;
    cnt_d    = cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   fill_d = fill_q + (AW+1)'(1);
        2'b01:   fill_d = fill_q - (AW+1)'(1);
        default: fill_d = fill_q;
      endcase
    end

    if (len_wr) len_d = i_user_data;

    if (flush || len_wr) begin
      cnt_d = '0;
    end else if (pop && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_user_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  // Register reads return pre-edge state one cycle after the strobe.
  always_ff @(posedge i_user_clk) begin
    if (!i_rst) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= i_user_rd_req;
      rd_data_q <= '0;
      if (i_user_rd_req && in_window) begin
        unique case (i_user_addr[3:0])
          OFS_LEN:    rd_data_q <= len_q;
          OFS_CNT:    rd_data_q <= cnt_q;
          OFS_STATUS: rd_data_q <= pack_status(full, empty, STATUS_FILL_W'(fill_q));
          default:    rd_data_q <= '0;
        endcase
      end
    end
  end

  // A LEN write outranks a same-cycle completing pop.
  always_ff @(posedge i_user_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      intr_req_q <= 1'b0;
    end else if (len_wr) begin
      state_q    <= (i_user_data != '0) ? ST_ARMED : ST_IDLE;
      intr_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          intr_req_q <= 1'b0;
        end
        ST_ARMED: begin
          if (pop && (cnt_d == len_q)) begin
            state_q    <= ST_PEND;
            intr_req_q <= 1'b1;
          end
        end
        ST_PEND: begin
          if (i_intr_ack) begin
            state_q    <= ST_IDLE;
            intr_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          intr_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after the edge.
  assign o_pcie_str_ack        = i_rst && push;
  assign o_user_str_data_valid = i_rst && !empty;
  assign o_user_str_data       = (i_rst && !empty) ? ram_rdata : '0;
  assign o_user_data           = i_rst ? rd_data_q : '0;
  assign o_user_rd_ack         = i_rst && rd_ack_q;
  assign o_intr_req            = i_rst && intr_req_q;

endmodule

// File: tb/tb_user_str_fifo.sv
// Randomised and directed scoreboard bench for user_str_fifo against a
// queue-based reference model of the stream, register map and interrupt.
module tb_user_str_fifo;

  localparam int          DEPTH = 16;
  localparam logic [19:0] BASE  = 20'h00100;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_pcie_str_data_valid;
  logic        o_pcie_str_ack;
  logic [63:0] i_pcie_str_data;
  logic        o_user_str_data_valid;
  logic        i_user_str_ack;
  logic [63:0] o_user_str_data;
  logic [19:0] i_user_addr;
  logic [31:0] i_user_data;
  logic        i_user_wr_req;
  logic        i_user_rd_req;
  logic [31:0] o_user_data;
  logic        o_user_rd_ack;
  logic        o_intr_req;
  logic        i_intr_ack;

  always #5 clk = ~clk;

  user_str_fifo #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .i_user_clk            (clk),
    .i_rst                 (i_rst),
    .i_pcie_str_data_valid (i_pcie_str_data_valid),
    .o_pcie_str_ack        (o_pcie_str_ack),
    .i_pcie_str_data       (i_pcie_str_data),
    .o_user_str_data_valid (o_user_str_data_valid),
    .i_user_str_ack        (i_user_str_ack),
    .o_user_str_data       (o_user_str_data),
    .i_user_addr           (i_user_addr),
    .i_user_data           (i_user_data),
    .i_user_wr_req         (i_user_wr_req),
    .i_user_rd_req         (i_user_rd_req),
    .o_user_data           (o_user_data),
    .o_user_rd_ack         (o_user_rd_ack),
    .o_intr_req            (o_intr_req),
    .i_intr_ack            (i_intr_ack)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents as a queue, plus block bookkeeping.
  logic [63:0] exp_q [$];
  logic [31:0] len_m;
  logic [31:0] cnt_m;
  bit          armed_m;
  bit          pend_m;
  bit          rd_pend;
  logic [31:0] rd_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] status_m();
    int n;
    n = exp_q.size();
    return {22'd0, n == DEPTH, n == 0, 8'(n)};
  endfunction

  // Output-side monitor: every handshake must deliver the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (o_user_str_data_valid === 1'b1 && i_user_str_ack === 1'b1) begin
        if (exp_q.size() == 0) check("pop_unexpected", 64'd1, 64'd0);
        else                   check("stream_data", o_user_str_data, exp_q.pop_front());
      end
    end
  end

  task automatic drive_idle();
    i_pcie_str_data_valid = 1'b0;
    i_pcie_str_data       = '0;
    i_user_str_ack        = 1'b0;
    i_user_addr           = '0;
    i_user_data           = '0;
    i_user_wr_req         = 1'b0;
    i_user_rd_req         = 1'b0;
    i_intr_ack            = 1'b0;
  endtask

  task automatic cycle(input bit          valid,
                       input logic [63:0] data,
                       input bit          uack,
                       input bit          iack  = 1'b0,
                       input bit          wr    = 1'b0,
                       input bit          rd    = 1'b0,
                       input logic [19:0] addr  = '0,
                       input logic [31:0] wdata = '0);
    int          n;
    bit          e_pop, e_push, win, e_flush, e_lenw;
    logic [3:0]  ofs;
    logic [31:0] r_exp;
    @(posedge clk);
    #1;
    i_pcie_str_data_valid = valid;
    i_pcie_str_data       = data;
    i_user_str_ack        = uack;
    i_intr_ack            = iack;
    i_user_wr_req         = wr;
    i_user_rd_req         = rd;
    i_user_addr           = addr;
    i_user_data           = wdata;

    n       = exp_q.size();
    e_pop   = (n > 0) && uack;
    e_push  = valid && ((n < DEPTH) || e_pop);
    win     = (addr[19:4] == BASE[19:4]);
    ofs     = addr[3:0];
    e_flush = wr && win && (ofs == 4'hC) && wdata[0];
    e_lenw  = wr && win && (ofs == 4'h0);
    r_exp   = '0;
    if (rd && win) begin
      case (ofs)
        4'h0:    r_exp = len_m;
        4'h4:    r_exp = cnt_m;
        4'h8:    r_exp = status_m();
        default: r_exp = '0;
      endcase
    end

    @(negedge clk);
    check("pcie_ack", o_pcie_str_ack, e_push);
    check("user_valid", o_user_str_data_valid, n > 0);
    check("intr_req", o_intr_req, pend_m);
    check("rd_ack", o_user_rd_ack, rd_pend);
    if (rd_pend) check("rd_data", o_user_data, rd_exp);
    rd_pend = rd;
    rd_exp  = r_exp;

    #1;
    if (e_flush)     exp_q.delete();
    else if (e_push) exp_q.push_back(data);

    if (e_flush || e_lenw)            cnt_m = '0;
    else if (e_pop && cnt_m != '1)    cnt_m = cnt_m + 32'd1;

    if (e_lenw) begin
      len_m   = wdata;
      armed_m = (wdata != 0);
      pend_m  = 1'b0;
    end else if (pend_m) begin
      if (iack) pend_m = 1'b0;
    end else if (armed_m && e_pop && cnt_m == len_m) begin
      pend_m  = 1'b1;
      armed_m = 1'b0;
    end
  endtask

  // One cycle with reset low: every output must already read zero.
  task automatic reset_cycle();
    @(posedge clk);
    #1;
    i_rst                 = 1'b0;
    i_pcie_str_data_valid = 1'b1;
    i_user_str_ack        = 1'b1;
    i_user_rd_req         = 1'b1;
    @(negedge clk);
    check("rst_pcie_ack", o_pcie_str_ack, 1'b0);
    check("rst_user_valid", o_user_str_data_valid, 1'b0);
    check("rst_user_data", o_user_str_data, 64'd0);
    check("rst_rd_data", o_user_data, 32'd0);
    check("rst_rd_ack", o_user_rd_ack, 1'b0);
    check("rst_intr", o_intr_req, 1'b0);
    #1;
    exp_q.delete();
    len_m   = '0;
    cnt_m   = '0;
    armed_m = 1'b0;
    pend_m  = 1'b0;
    rd_pend = 1'b0;
    @(posedge clk);
    #1;
    drive_idle();
    i_rst = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] ad;
    logic [31:0] wd;
    bit          v, a, ia, w, r;

    drive_idle();
    i_rst   = 1'b0;
    len_m   = '0;
    cnt_m   = '0;
    armed_m = 1'b0;
    pend_m  = 1'b0;
    rd_pend = 1'b0;
    rd_exp  = '0;
    reset_cycle();
    reset_cycle();

    // Fill 16 words with the consumer stalled; the 17th offer is refused.
    for (int i = 1; i <= 17; i++) cycle(1'b1, 64'(i), 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, BASE + 20'h8);
    cycle(1'b0, '0, 1'b0);
    check("status_full", status_m(), 32'h210);

    // Full FIFO with simultaneous push and pop keeps the level at DEPTH.
    cycle(1'b1, 64'h55, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, BASE + 20'h8);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1);

    // Continuous stream of 100 incrementing words.
    for (int i = 0; i < 100; i++) cycle(1'b1, 64'(32'h1000 + i), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

    // Block of 8 words raises the interrupt after the 8th pop.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, BASE + 20'h0, 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b1, 64'(32'hA0 + i), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, BASE + 20'h4);
    cycle(1'b0, '0, 1'b0);
    check("intr_raised", o_intr_req, 1'b1);
    check("cnt_block", cnt_m, 32'd8);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("intr_cleared", o_intr_req, 1'b0);

    // Flush with five words buffered.
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'(32'hF0 + i), 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, BASE + 20'hC, 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, BASE + 20'h8);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, BASE + 20'h4);
    cycle(1'b0, '0, 1'b0);
    check("flush_valid", o_user_str_data_valid, 1'b0);

    // Out-of-window read acks with zero.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00200);
    cycle(1'b0, '0, 1'b0);

    // Reset in the middle of a buffered block.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, BASE + 20'h0, 32'd20);
    for (int i = 0; i < 10; i++) cycle(1'b1, 64'(32'hB0 + i), 1'b0);
    reset_cycle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, BASE + 20'h0);
    cycle(1'b0, '0, 1'b0);

    // Randomised traffic mixing stream, register and interrupt activity.
    for (int i = 0; i < 800; i++) begin
      v  = ($urandom % 4) != 0;
      a  = ($urandom % 3) != 0;
      ia = ($urandom % 4) == 0;
      w  = ($urandom % 30) == 0;
      r  = ($urandom % 6) == 0;
      if ($urandom % 10 == 0) ad = 20'($urandom);
      else                    ad = BASE + 20'(($urandom % 4) * 4);
      if (ad[3:0] == 4'hC) wd = 32'($urandom % 2);
      else                 wd = 32'($urandom % 12);
      cycle(v, {$urandom, $urandom}, a, ia, w, r, ad, wd);
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1);
    check("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
